// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT output in, natural-order bins out.
// One bank fills while the other drains through a registered output stage.
//
// bank state | meaning
// EMPTY      | free, waiting for the first sample of a frame
// FILLING    | receiving samples of the current frame
// FULL       | frame complete, not yet scheduled for readout
// DRAINING   | being read out in natural index order
module fft_bitrev_reorder #(
    parameter int DW    = 16,
    parameter int LOG2N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid_in,
    input  logic [DW-1:0]    i_in_re,
    input  logic [DW-1:0]    i_in_im,
    output logic             o_ready_in,
    output logic             o_valid_out,
    output logic [DW-1:0]    o_out_re,
    output logic [DW-1:0]    o_out_im,
    output logic [LOG2N-1:0] o_out_idx,
    output logic             o_out_last,
    input  logic             i_ready_out
);
    localparam int N = 1 << LOG2N;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_st_t;

    bank_st_t         r_bank_st     [2];
    bank_st_t         w_bank_st_nxt [2];
    logic             r_run;
    logic             r_wr_bank;
    logic             r_ld_bank;
    logic             r_rd_bank;
    logic [LOG2N-1:0] r_wr_cnt;
    logic [LOG2N-1:0] r_ld_cnt;
    logic [DW-1:0]    r_mem_re [2*N];
    logic [DW-1:0]    r_mem_im [2*N];
    logic             r_valid_out;
    logic [DW-1:0]    r_out_re;
    logic [DW-1:0]    r_out_im;
    logic [LOG2N-1:0] r_out_idx;
    logic             r_out_last;

    logic             w_in_fire;
    logic             w_wr_done;
    logic [LOG2N-1:0] w_wr_addr;
    logic             w_ld_fire;
    logic             w_ld_wrap;
    logic             w_ld_bank_nxt;
    logic             w_out_fire;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    // r_run keeps ready_in low through reset and releases it on the first edge after.
    assign o_ready_in = r_run && (r_bank_st[r_wr_bank] == BANK_EMPTY ||
                                  r_bank_st[r_wr_bank] == BANK_FILLING);
    assign w_in_fire  = i_valid_in && o_ready_in;
    assign w_wr_done  = w_in_fire && (r_wr_cnt == '1);
    assign w_wr_addr  = bitrev(r_wr_cnt);

    // The load pointer runs one sample ahead of the output register and can move on
    // to the next bank while the last sample of the previous one is still waiting.
    assign w_ld_fire     = (r_bank_st[r_ld_bank] == BANK_DRAINING) && (!r_valid_out || i_ready_out);
    assign w_ld_wrap     = w_ld_fire && (r_ld_cnt == '1);
    assign w_ld_bank_nxt = r_ld_bank ^ w_ld_wrap;
    assign w_out_fire    = r_valid_out && i_ready_out && r_out_last;

    // Writes only touch EMPTY/FILLING banks, arming only FULL, freeing only DRAINING,
    // so the three updates can never collide on one bank.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_bank_st_nxt[b] = r_bank_st[b];
            if (w_in_fire && r_wr_bank == 1'(b))
                w_bank_st_nxt[b] = w_wr_done ? BANK_FULL : BANK_FILLING;
            if (r_bank_st[b] == BANK_FULL && w_ld_bank_nxt == 1'(b))
                w_bank_st_nxt[b] = BANK_DRAINING;
            if (w_out_fire && r_rd_bank == 1'(b))
                w_bank_st_nxt[b] = BANK_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_st[0] <= BANK_EMPTY;
            r_bank_st[1] <= BANK_EMPTY;
            r_run        <= 1'b0;
            r_wr_bank    <= 1'b0;
            r_ld_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_wr_cnt     <= '0;
            r_ld_cnt     <= '0;
            r_valid_out  <= 1'b0;
            r_out_re     <= '0;
            r_out_im     <= '0;
            r_out_idx    <= '0;
            r_out_last   <= 1'b0;
        end else begin
            r_run     <= 1'b1;
            r_bank_st <= w_bank_st_nxt;
            if (w_in_fire) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_wr_done) r_wr_bank <= ~r_wr_bank;
            end
            if (w_ld_fire) begin
                r_ld_cnt    <= r_ld_cnt + 1'b1;
                r_ld_bank   <= w_ld_bank_nxt;
                r_out_re    <= r_mem_re[{r_ld_bank, r_ld_cnt}];
                r_out_im    <= r_mem_im[{r_ld_bank, r_ld_cnt}];
                r_out_idx   <= r_ld_cnt;
                r_out_last  <= (r_ld_cnt == '1);
                r_valid_out <= 1'b1;
            end else if (i_ready_out) begin
                r_valid_out <= 1'b0;
            end
            if (w_out_fire) r_rd_bank <= ~r_rd_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_mem_re[{r_wr_bank, w_wr_addr}] <= i_in_re;
            r_mem_im[{r_wr_bank, w_wr_addr}] <= i_in_im;
        end
    end

    assign o_valid_out = r_valid_out;
    assign o_out_re    = r_out_re;
    assign o_out_im    = r_out_im;
    assign o_out_idx   = r_out_idx;
    assign o_out_last  = r_out_last;

endmodule
